// File: rtl/ctrl_types_pkg.sv
// Shared controller types: host operation codes, response outcomes and a
// small helper that decides whether an operation can be issued to the
// memory controller.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAIL    = 2'd1,
    ST_BADOP   = 2'd2,
    ST_TIMEOUT = 2'd3
  } resp_status_e;

  // True for operations that the controller knows how to execute.
  function automatic logic is_issuable_op(input operation_e op);
    logic ok_v;
    case (op)
      READ:    ok_v = 1'b1;
      UPSERT:  ok_v = 1'b1;
      DELETE:  ok_v = 1'b1;
      default: ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

endpackage

// File: rtl/cache_if.sv
// Host-side request front end for the cache controller. Accepts one host
// request at a time, issues it to the controller as a single-cycle opcode
// pulse, waits for a fresh rising edge on the controller ready line (or a
// bounded timeout) and returns a held response until the host accepts it.
module cache_if
  import ctrl_types_pkg::*;
#(
  parameter int KEY_W   = 16,
  parameter int VAL_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  operation_e         req_op,
  input  logic [KEY_W-1:0]   req_key,
  input  logic [VAL_W-1:0]   req_value,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [VAL_W-1:0]   resp_value,
  output resp_status_e       resp_status,
  output operation_e         operation_out,
  output logic [KEY_W-1:0]   key_out,
  output logic [VAL_W-1:0]   value_out,
  input  logic               ctrl_rdy,
  input  logic               ctrl_succ,
  input  logic [VAL_W-1:0]   rd_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Counter is wide enough to hold TIMEOUT itself, so it can never wrap
  // before the limit comparison fires.
  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e             state_r, state_s;
  operation_e         op_r, op_s;
  logic [KEY_W-1:0]   key_r, key_s;
  logic [VAL_W-1:0]   val_r, val_s;
  logic [VAL_W-1:0]   resp_value_r, resp_value_s;
  resp_status_e       resp_status_r, resp_status_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               rdy_q_r;
  logic               rdy_rise_s;

  // Only a low-to-high transition of ctrl_rdy counts as completion; a level
  // that is already high when WAIT is entered is ignored.
  assign rdy_rise_s = ctrl_rdy && !rdy_q_r;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      op_r          <= NOOP;
      key_r         <= {KEY_W{1'b0}};
      val_r         <= {VAL_W{1'b0}};
      resp_value_r  <= {VAL_W{1'b0}};
      resp_status_r <= ST_OK;
      cnt_r         <= CNT_ZERO;
      rdy_q_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      op_r          <= op_s;
      key_r         <= key_s;
      val_r         <= val_s;
      resp_value_r  <= resp_value_s;
      resp_status_r <= resp_status_s;
      cnt_r         <= cnt_s;
      rdy_q_r       <= ctrl_rdy;
    end
  end

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    state_s       = state_r;
    op_s          = op_r;
    key_s         = key_r;
    val_s         = val_r;
    resp_value_s  = resp_value_r;
    resp_status_s = resp_status_r;
    cnt_s         = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          op_s         = req_op;
          key_s        = req_key;
          val_s        = req_value;
          resp_value_s = {VAL_W{1'b0}};
          if (is_issuable_op(req_op)) begin
            resp_status_s = ST_OK;
            state_s       = ISSUE;
          end else begin
            resp_status_s = ST_BADOP;
            state_s       = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = CNT_ZERO;
        state_s = WAIT;
      end
      WAIT: begin
        // A completion edge takes priority over the timeout limit.
        if (rdy_rise_s) begin
          resp_status_s = ctrl_succ ? ST_OK : ST_FAIL;
          if (op_r == READ) begin
            resp_value_s = rd_data;
          end else begin
            resp_value_s = resp_value_r;
          end
          state_s = RESP;
        end else if (cnt_r >= CNT_LIMIT) begin
          resp_status_s = ST_TIMEOUT;
          state_s       = RESP;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode straight from registered state so nothing glitches.
  always_comb begin
    req_ready   = (state_r == IDLE);
    busy        = (state_r != IDLE);
    resp_valid  = (state_r == RESP);
    resp_value  = resp_value_r;
    resp_status = resp_status_r;
    key_out     = key_r;
    value_out   = val_r;
    if (state_r == ISSUE) begin
      operation_out = op_r;
    end else begin
      operation_out = NOOP;
    end
  end

endmodule

// File: doc/cache_if.md
CACHE_IF -- requirements
Module: cache_if

Interface
REQ-001 SHALL have parameter KEY_W, default 16, key width in bits.
REQ-002 SHALL have parameter VAL_W, default 32, value width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles; legal range ≥2.
REQ-004 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req_valid  input  1  host request valid.
REQ-007 SHALL have port: req_ready  output  1  block can accept a request.
REQ-008 SHALL have port: req_op  input  operation_e  requested operation.
REQ-009 SHALL have port: req_key  input  KEY_W  request key.
REQ-010 SHALL have port: req_value  input  VAL_W  upsert value.
REQ-011 SHALL have port: resp_valid  output  1  response valid.
REQ-012 SHALL have port: resp_ready  input  1  host accepts response.
REQ-013 SHALL have port: resp_value  output  VAL_W  read data.
REQ-014 SHALL have port: resp_status  output  resp_status_e  outcome: OK, FAIL, BADOP, TIMEOUT.
REQ-015 SHALL have port: operation_out  output  operation_e  operation to controller.
REQ-016 SHALL have port: key_out  output  KEY_W  latched key to memory.
REQ-017 SHALL have port: value_out  output  VAL_W  latched value to memory.
REQ-018 SHALL have port: ctrl_rdy  input  1  controller ready (rdy_out).
REQ-019 SHALL have port: ctrl_succ  input  1  controller op_succ.
REQ-020 SHALL have port: rd_data  input  VAL_W  memory read data.
REQ-021 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-023 SHALL drive req_ready=1 only in IDLE.
REQ-024 IDLE: on req_valid&&req_ready, SHALL latch req_op/req_key/req_value, clear the status and value registers, and go to ISSUE; if req_op is not READ, UPSERT or DELETE, SHALL instead set status BADOP and go to RESP.
REQ-025 ISSUE: SHALL drive operation_out = latched op for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-026 SHALL drive operation_out=NOOP in every state other than ISSUE.
REQ-027 SHALL hold key_out/value_out at latched values, unchanged from ISSUE through RESP.
REQ-028 SHALL register ctrl_rdy every cycle into rdy_q; rising edge = ctrl_rdy&&!rdy_q.
REQ-029 WAIT: on rising edge, SHALL capture status OK if ctrl_succ=1 else FAIL, capture rd_data into resp_value when op=READ, and go to RESP the next cycle.
REQ-030 WAIT: SHALL increment the timeout counter each cycle without an edge; at count TIMEOUT-1, SHALL set status TIMEOUT and go to RESP.
REQ-031 When a rising edge and the timeout limit occur in the same cycle, the rising edge SHALL win (status OK/FAIL).
REQ-032 SHALL size the counter as $clog2(TIMEOUT+1) bits and never let it wrap.
REQ-033 A ctrl_rdy already high on entry to WAIT without a new edge SHALL NOT complete the operation.
REQ-034 RESP: SHALL hold resp_valid=1 and resp_value/resp_status stable until resp_ready=1, then go to IDLE the next cycle.
REQ-035 SHALL preserve resp_value/resp_status after the handshake until the next accepted request.
REQ-036 SHALL deliver the minimum latency from request accept to resp_valid as 3 cycles (ISSUE, WAIT with edge, RESP).

Reset
REQ-037 While rst_n=0, SHALL hold state=IDLE, req_ready=1, resp_valid=0, busy=0, operation_out=NOOP, key_out/value_out/resp_value=0, resp_status=OK, counter=0, rdy_q=0.
REQ-038 Reset asserted mid-operation SHALL abort with no response issued.

Structure
REQ-039 ctrl_types_pkg SHALL hold operation_e (NOOP, READ, UPSERT, DELETE) and a new resp_status_e.
REQ-040 The FSM state enum SHALL be local to cache_if; no sub-module is required.

Verification
REQ-041 Bench SHALL cover: UPSERT key=0x0012 val=0xDEADBEEF, ctrl_rdy edge with succ=1 two cycles after ISSUE -> operation_out=UPSERT for 1 cycle, resp_status=OK.
REQ-042 Bench SHALL cover: READ key=0x0005, edge with succ=1, rd_data=0xCAFEF00D -> resp_value=0xCAFEF00D, status OK.
REQ-043 Bench SHALL cover: DELETE with succ=0 at the edge -> status FAIL, resp_value=0.
REQ-044 Bench SHALL cover: TIMEOUT=4, ctrl_rdy held low -> status TIMEOUT after 4 WAIT cycles; edge in the 4th cycle -> OK/FAIL.
REQ-045 Bench SHALL cover: resp_ready low for 5 cycles -> resp_valid and data held stable, req_ready=0 throughout.
REQ-046 Bench SHALL cover: rst_n pulsed low in WAIT -> all outputs at reset values; the next request completes normally.
